// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic [1:0] DBITS_5 = 2'b00;
    localparam logic [1:0] DBITS_6 = 2'b01;
    localparam logic [1:0] DBITS_7 = 2'b10;
    localparam logic [1:0] DBITS_8 = 2'b11;

    localparam int MIN_CLK_DIV = 4;

    // Number of data bits (5..8) for a cfg_data_bits encoding.
    function automatic logic [3:0] dbits_count(input logic [1:0] enc);
        return 4'd5 + {2'b00, enc};
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head is read combinationally
// from registered storage.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       data_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   empty_o,
    output logic                   full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push, do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
    assign rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;

    // Pointer registers; reset discards contents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage written on the clock edge only.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
    end

    assign data_o  = mem_q[rptr_q[AW-1:0]];
    assign level_o = wptr_q - rptr_q;
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit path: byte FIFO feeding a serialiser with a per-frame
// latched format (5-8 data bits, optional parity, 1 or 2 stop bits).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DIV_W  = 16,
    parameter int LOW_WM = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DIV_W-1:0]       clk_div,
    input  logic [1:0]             cfg_data_bits,
    input  logic                   cfg_parity_en,
    input  logic                   cfg_parity_odd,
    input  logic                   cfg_stop2,
    input  logic                   push_valid,
    input  logic [7:0]             push_data,
    output logic                   push_ready,
    input  logic                   clr_ovf,
    output logic                   tx,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level,
    output logic                   empty,
    output logic                   full,
    output logic                   low_wm_irq,
    output logic                   overflow,
    output logic                   tx_done
);
    localparam int LW = $clog2(DEPTH) + 1;

    tx_state_t        state_q, state_d;
    logic [DIV_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [3:0]       nbits_q, nbits_d;
    logic             pen_q, pen_d;
    logic             par_q, par_d;
    logic             stop2_q, stop2_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tx_q, tx_d;
    logic             ovf_q, ovf_d;

    logic [7:0]       fifo_data;
    logic [LW-1:0]    fifo_level;
    logic             fifo_empty, fifo_full;
    logic             fifo_pop;
    logic [DIV_W-1:0] div_eff;
    logic [7:0]       data_mask;
    logic             bit_end, last_data, last_stop, frame_end;

    uart_sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_valid),
        .data_i  (push_data),
        .pop_i   (fifo_pop),
        .data_o  (fifo_data),
        .level_o (fifo_level),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign div_eff   = (clk_div < DIV_W'(MIN_CLK_DIV)) ? DIV_W'(MIN_CLK_DIV) : clk_div;
    assign data_mask = 8'hFF >> (2'd3 - cfg_data_bits);
    assign bit_end   = (baud_q == div_q - 1'b1);
    assign last_data = ({1'b0, bit_q} == nbits_q - 4'd1);
    assign last_stop = (bit_q == {2'b00, stop2_q});
    assign frame_end = (state_q == STOP) && bit_end && last_stop;
    // A new frame starts either from idle or straight out of the last stop cycle.
    assign fifo_pop  = !fifo_empty && ((state_q == IDLE) || frame_end);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            nbits_q <= 4'd8;
            pen_q   <= 1'b0;
            par_q   <= 1'b0;
            stop2_q <= 1'b0;
            div_q   <= DIV_W'(MIN_CLK_DIV);
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            nbits_q <= nbits_d;
            pen_q   <= pen_d;
            par_q   <= par_d;
            stop2_q <= stop2_d;
            div_q   <= div_d;
            tx_q    <= tx_d;
        end
    end

    // Next state, frame latching and bit/baud counting.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        nbits_d = nbits_q;
        pen_d   = pen_q;
        par_d   = par_q;
        stop2_d = stop2_q;
        div_d   = div_q;
        case (state_q)
            IDLE:    if (fifo_pop) state_d = START;
            START:   if (bit_end) state_d = DATA;
            DATA: begin
                if (bit_end) begin
                    if (last_data) state_d = pen_q ? PARITY : STOP;
                    else           shift_d = shift_q >> 1;
                end
            end
            PARITY:  if (bit_end) state_d = STOP;
            STOP:    if (frame_end) state_d = fifo_pop ? START : IDLE;
            default: state_d = IDLE;
        endcase
        if (fifo_pop) begin
            shift_d = fifo_data;
            nbits_d = dbits_count(cfg_data_bits);
            pen_d   = cfg_parity_en;
            par_d   = (^(fifo_data & data_mask)) ^ cfg_parity_odd;
            stop2_d = cfg_stop2;
            div_d   = div_eff;
        end
        if ((state_d != state_q) || (state_q == IDLE)) begin
            baud_d = '0;
            bit_d  = '0;
        end else if (bit_end) begin
            baud_d = '0;
            bit_d  = bit_q + 3'd1;
        end else begin
            baud_d = baud_q + 1'b1;
            bit_d  = bit_q;
        end
    end

    // Outputs: registered line level follows the upcoming state.
    always_comb begin
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
        busy    = (state_q != IDLE);
        tx_done = frame_end;
    end

    // Sticky overflow; a drop on the same edge as a clear wins.
    always_ff @(posedge clk) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign ovf_d      = (push_valid && fifo_full) ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
    assign tx         = tx_q;
    assign level      = fifo_level;
    assign empty      = fifo_empty;
    assign full       = fifo_full;
    assign push_ready = rst_n && !fifo_full;
    assign low_wm_irq = (fifo_level <= LW'(LOW_WM));
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] clk_div;
    logic [1:0]  cfg_data_bits;
    logic        cfg_parity_en, cfg_parity_odd, cfg_stop2;
    logic        push_valid;
    logic [7:0]  push_data;
    logic        push_ready, clr_ovf, tx, busy, empty, full, low_wm_irq, overflow, tx_done;
    logic [4:0]  level;

    int checks   = 0;
    int failures = 0;

    int fr_byte[20], fr_nb[20], fr_pen[20], fr_podd[20], fr_stop2[20], fr_div[20];
    int fr_start[20], fr_len[20];

    uart_tx_fifo #(.DEPTH(16), .DIV_W(16), .LOW_WM(4)) dut (
        .clk(clk), .rst_n(rst_n), .clk_div(clk_div), .cfg_data_bits(cfg_data_bits),
        .cfg_parity_en(cfg_parity_en), .cfg_parity_odd(cfg_parity_odd), .cfg_stop2(cfg_stop2),
        .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
        .clr_ovf(clr_ovf), .tx(tx), .busy(busy), .level(level), .empty(empty),
        .full(full), .low_wm_irq(low_wm_irq), .overflow(overflow), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    function automatic int div_eff(input int raw);
        return (raw < 4) ? 4 : raw;
    endfunction

    // Line level of bit position idx within frame k: start, data LSB first, parity, stops.
    function automatic int exp_bit(input int k, input int idx);
        int ones;
        if (idx == 0) return 0;
        if (idx <= fr_nb[k]) return (fr_byte[k] >> (idx - 1)) & 1;
        if (fr_pen[k] != 0 && idx == fr_nb[k] + 1) begin
            ones = 0;
            for (int b = 0; b < fr_nb[k]; b++) ones += (fr_byte[k] >> b) & 1;
            return (ones % 2) ^ fr_podd[k];
        end
        return 1;
    endfunction

    task automatic set_frame(input int k, input int b, input int nb, input int pen,
                             input int podd, input int st2, input int dv);
        fr_byte[k] = b; fr_nb[k] = nb; fr_pen[k] = pen;
        fr_podd[k] = podd; fr_stop2[k] = st2; fr_div[k] = dv;
    endtask

    // Push n frames on consecutive edges (DUT idle and empty) and follow every cycle.
    task automatic run_scenario(input int n, input string tag);
        int total, o, exp_tx, exp_done, exp_busy, exp_lvl, popped, pushed, nxt, done_cnt;
        for (int i = 0; i < n; i++) begin
            fr_len[i]   = div_eff(fr_div[i]) * (2 + fr_nb[i] + fr_pen[i] + fr_stop2[i]);
            fr_start[i] = (i == 0) ? 2 : fr_start[i-1] + fr_len[i-1];
        end
        total = fr_start[n-1] + fr_len[n-1] + 2;
        done_cnt = 0;
        for (int t = 0; t <= total; t++) begin
            @(negedge clk);
            if (t >= 1) begin
                exp_tx = 1; exp_done = 0; exp_busy = 0; popped = 0;
                for (int j = 0; j < n; j++) begin
                    if (fr_start[j] <= t) popped++;
                    if (t >= fr_start[j] && t < fr_start[j] + fr_len[j]) begin
                        o = t - fr_start[j];
                        exp_busy = 1;
                        exp_tx   = exp_bit(j, o / div_eff(fr_div[j]));
                        exp_done = (o == fr_len[j] - 1) ? 1 : 0;
                    end
                end
                pushed  = (t < n) ? t : n;
                exp_lvl = pushed - popped;
                checks += 6;
                if (tx !== 1'(exp_tx)) begin
                    failures++;
                    if (failures < 40) $display("FAIL %s_tx t=%0d got=%0b want=%0d", tag, t, tx, exp_tx);
                end
                if (tx_done !== 1'(exp_done)) begin
                    failures++;
                    if (failures < 40) $display("FAIL %s_tx_done t=%0d got=%0b want=%0d", tag, t, tx_done, exp_done);
                end
                if (busy !== 1'(exp_busy)) begin
                    failures++;
                    if (failures < 40) $display("FAIL %s_busy t=%0d got=%0b want=%0d", tag, t, busy, exp_busy);
                end
                if (level !== 5'(exp_lvl)) begin
                    failures++;
                    if (failures < 40) $display("FAIL %s_level t=%0d got=%0d want=%0d", tag, t, level, exp_lvl);
                end
                if (empty !== (exp_lvl == 0)) begin
                    failures++;
                    if (failures < 40) $display("FAIL %s_empty t=%0d got=%0b want=%0b", tag, t, empty, exp_lvl == 0);
                end
                if (low_wm_irq !== (exp_lvl <= 4)) begin
                    failures++;
                    if (failures < 40) $display("FAIL %s_low_wm t=%0d got=%0b want=%0b", tag, t, low_wm_irq, exp_lvl <= 4);
                end
                if (tx_done === 1'b1) done_cnt++;
            end
            // Present the format of the next frame to be popped; mid-frame changes must be ignored.
            nxt = n - 1;
            for (int j = n - 1; j >= 0; j--) if (fr_start[j] >= t + 1) nxt = j;
            cfg_data_bits  = 2'(fr_nb[nxt] - 5);
            cfg_parity_en  = 1'(fr_pen[nxt]);
            cfg_parity_odd = 1'(fr_podd[nxt]);
            cfg_stop2      = 1'(fr_stop2[nxt]);
            clk_div        = 16'(fr_div[nxt]);
            push_valid     = (t < n);
            push_data      = (t < n) ? 8'(fr_byte[t]) : 8'h00;
        end
        push_valid = 1'b0;
        checks++;
        if (done_cnt != n) begin
            failures++;
            $display("FAIL %s_done_count got=%0d want=%0d", tag, done_cnt, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; push_valid = 1'b0; push_data = 8'h00; clr_ovf = 1'b0;
        clk_div = 16'd4; cfg_data_bits = 2'b11; cfg_parity_en = 1'b0;
        cfg_parity_odd = 1'b0; cfg_stop2 = 1'b0;
        @(negedge clk);
        checks += 9;
        if (tx !== 1'b1)         begin failures++; $display("FAIL reset_tx got=%0b want=1", tx); end
        if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%0b want=0", busy); end
        if (level !== 5'd0)      begin failures++; $display("FAIL reset_level got=%0d want=0", level); end
        if (empty !== 1'b1)      begin failures++; $display("FAIL reset_empty got=%0b want=1", empty); end
        if (full !== 1'b0)       begin failures++; $display("FAIL reset_full got=%0b want=0", full); end
        if (push_ready !== 1'b0) begin failures++; $display("FAIL reset_push_ready got=%0b want=0", push_ready); end
        if (overflow !== 1'b0)   begin failures++; $display("FAIL reset_overflow got=%0b want=0", overflow); end
        if (tx_done !== 1'b0)    begin failures++; $display("FAIL reset_tx_done got=%0b want=0", tx_done); end
        if (low_wm_irq !== 1'b1) begin failures++; $display("FAIL reset_low_wm got=%0b want=1", low_wm_irq); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (push_ready !== 1'b1) begin failures++; $display("FAIL release_push_ready got=%0b want=1", push_ready); end
    endtask

    task automatic test_8n1();
        set_frame(0, 8'hA5, 8, 0, 0, 0, 4);
        run_scenario(1, "8n1_a5");
    endtask

    task automatic test_parity();
        set_frame(0, 8'h55, 7, 1, 0, 1, 4);
        run_scenario(1, "7e2");
        set_frame(0, 8'h55, 7, 1, 1, 1, 4);
        run_scenario(1, "7o2");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) set_frame(k, int'($urandom_range(0, 255)), 5, 0, 0, 0, 2);
        run_scenario(3, "b2b_5n1");
    endtask

    task automatic test_cfg_change();
        set_frame(0, int'($urandom_range(0, 255)), 8, 0, 0, 0, 4);
        set_frame(1, int'($urandom_range(0, 255)), 5, 0, 0, 0, 4);
        run_scenario(2, "cfg_change");
    endtask

    task automatic test_random();
        int n;
        for (int r = 0; r < 5; r++) begin
            n = int'($urandom_range(1, 4));
            for (int k = 0; k < n; k++)
                set_frame(k, int'($urandom_range(0, 255)), int'($urandom_range(5, 8)),
                          int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                          int'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
            run_scenario(n, "random");
        end
    endtask

    task automatic test_overflow();
        cfg_data_bits = 2'b11; cfg_parity_en = 1'b0; cfg_stop2 = 1'b0; clk_div = 16'd4;
        for (int t = 0; t <= 16; t++) begin
            @(negedge clk);
            if (t == 1 || t == 2) begin
                checks++;
                if (level !== 5'd1) begin failures++; $display("FAIL ovf_first_pop_level t=%0d got=%0d want=1", t, level); end
            end
            if (t == 2) begin
                checks++;
                if (busy !== 1'b1) begin failures++; $display("FAIL ovf_first_pop_busy got=%0b want=1", busy); end
            end
            push_valid = 1'b1;
            push_data  = 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        checks += 4;
        if (level !== 5'd16)     begin failures++; $display("FAIL ovf_level_full got=%0d want=16", level); end
        if (full !== 1'b1)       begin failures++; $display("FAIL ovf_full got=%0b want=1", full); end
        if (push_ready !== 1'b0) begin failures++; $display("FAIL ovf_push_ready got=%0b want=0", push_ready); end
        if (overflow !== 1'b0)   begin failures++; $display("FAIL ovf_no_drop_yet got=%0b want=0", overflow); end
        @(negedge clk);
        checks += 2;
        if (overflow !== 1'b1)   begin failures++; $display("FAIL ovf_set got=%0b want=1", overflow); end
        if (level !== 5'd16)     begin failures++; $display("FAIL ovf_drop_level got=%0d want=16", level); end
        push_valid = 1'b0; clr_ovf = 1'b1;
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0)   begin failures++; $display("FAIL ovf_clear got=%0b want=0", overflow); end
        push_valid = 1'b1; clr_ovf = 1'b1;
        @(negedge clk);
        checks++;
        if (overflow !== 1'b1)   begin failures++; $display("FAIL ovf_set_wins got=%0b want=1", overflow); end
        push_valid = 1'b0; clr_ovf = 1'b0;
        @(negedge clk);
        checks++;
        if (overflow !== 1'b1)   begin failures++; $display("FAIL ovf_sticky got=%0b want=1", overflow); end
        rst_n = 1'b0;
        @(negedge clk);
        checks += 4;
        if (level !== 5'd0)      begin failures++; $display("FAIL ovf_rst_level got=%0d want=0", level); end
        if (overflow !== 1'b0)   begin failures++; $display("FAIL ovf_rst_overflow got=%0b want=0", overflow); end
        if (busy !== 1'b0)       begin failures++; $display("FAIL ovf_rst_busy got=%0b want=0", busy); end
        if (tx !== 1'b1)         begin failures++; $display("FAIL ovf_rst_tx got=%0b want=1", tx); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        cfg_data_bits = 2'b11; cfg_parity_en = 1'b0; cfg_stop2 = 1'b0; clk_div = 16'd4;
        for (int t = 0; t <= 12; t++) begin
            @(negedge clk);
            push_valid = (t < 3);
            push_data  = 8'(t * 8'h11);
        end
        // Now in the second data bit of 0x00.
        checks += 3;
        if (tx !== 1'b0)     begin failures++; $display("FAIL midrst_pre_tx got=%0b want=0", tx); end
        if (busy !== 1'b1)   begin failures++; $display("FAIL midrst_pre_busy got=%0b want=1", busy); end
        if (level !== 5'd2)  begin failures++; $display("FAIL midrst_pre_level got=%0d want=2", level); end
        rst_n = 1'b0;
        @(negedge clk);
        checks += 4;
        if (tx !== 1'b1)      begin failures++; $display("FAIL midrst_tx got=%0b want=1", tx); end
        if (level !== 5'd0)   begin failures++; $display("FAIL midrst_level got=%0d want=0", level); end
        if (busy !== 1'b0)    begin failures++; $display("FAIL midrst_busy got=%0b want=0", busy); end
        if (tx_done !== 1'b0) begin failures++; $display("FAIL midrst_tx_done got=%0b want=0", tx_done); end
        rst_n = 1'b1;
        set_frame(0, int'($urandom_range(0, 255)), int'($urandom_range(5, 8)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
        run_scenario(1, "after_rst");
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_back_to_back();
        test_cfg_change();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmit path: a DEPTH-entry byte FIFO feeding a serialiser with runtime-selectable frame format (5–8 data bits, optional even/odd parity, 1 or 2 stop bits). It replaces the fixed 4-entry, 8N1-only TX FIFO and transmitter pair behind the Wishbone control block in the user project. The block adds backpressure, a sticky overflow flag, a low-watermark interrupt and back-to-back frame transmission.

## Interface
Parameters:
- DEPTH, 16 — FIFO entries; power of 2, ≥2
- DIV_W, 16 — width of clk_div
- LOW_WM, 4 — low_wm_irq asserts when level ≤ LOW_WM; 0 ≤ LOW_WM < DEPTH

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- clk_div  in  DIV_W  clk cycles per bit; values < 4 are treated as 4
- cfg_data_bits  in  2  00=5, 01=6, 10=7, 11=8 data bits
- cfg_parity_en  in  1  append a parity bit
- cfg_parity_odd  in  1  1=odd, 0=even parity
- cfg_stop2  in  1  1=two stop bits
- push_valid  in  1  write request
- push_data  in  8  byte; only low N bits are sent
- push_ready  out  1  = !full
- clr_ovf  in  1  clears overflow
- tx  out  1  serial line, idle high, registered
- busy  out  1  frame in progress
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- empty  out  1  level==0
- full  out  1  level==DEPTH
- low_wm_irq  out  1  level ≤ LOW_WM
- overflow  out  1  sticky: push attempted while full
- tx_done  out  1  one-cycle pulse at end of each frame

## Operation
- Push: accepted on an edge with push_valid && !full. push_valid && full drops the byte and sets overflow.
- overflow: cleared by clr_ovf. If set and clear occur on the same edge, set wins.
- FIFO: read/write pointers are $clog2(DEPTH)+1 bits wide and wrap naturally. Full is pointers equal except MSB. level = wptr − rptr.
- Push and pop on the same edge: level unchanged, both operations take effect.
- Serialiser FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE, !empty: pop the head into the shift register. Latch cfg_* and the effective clk_div for the whole frame; changes mid-frame are ignored. Go to START.
  - START: tx=0 for one bit time, then DATA.
  - DATA: send N bits LSB first, one bit time each. Then PARITY if enabled, else STOP.
  - PARITY: even = XOR of the N data bits; odd = its inverse.
  - STOP: tx=1 for 1 or 2 bit times. On the final cycle, pulse tx_done. If !empty, pop and go straight to START (no idle gap); else go to IDLE.
- Bit counter counts 0..div−1 using latched div. Frame length = div × (1 + N + P + S) cycles exactly.
- busy = (state != IDLE).
- Reset values: tx=1, busy=0, level=0, empty=1, full=0, push_ready=0 during reset then 1, overflow=0, tx_done=0, low_wm_irq=1, state IDLE.
- Reset mid-frame aborts the frame. tx returns high on the reset edge and the FIFO contents are discarded.

## Timing
- Push accepted at edge E into an empty FIFO while IDLE: level=1 after E. Pop at E+1: level=0, tx low from E+1.
- Status outputs (empty, full, level, push_ready, low_wm_irq) are combinational from the registered pointers and valid the cycle after the causing edge.
- tx_done is high exactly the last cycle of the final stop bit. For back-to-back frames, the next start bit begins on the following cycle.
- Throughput: one frame per div × frame_bits cycles, with no inter-frame gap while the FIFO is non-empty.

## Structure
- Shared package uart_pkg holds:
  - the tx_state_t enum (IDLE, START, DATA, PARITY, STOP)
  - DBITS_5..DBITS_8 encodings
  - MIN_CLK_DIV=4
- Sub-module uart_sync_fifo #(WIDTH, DEPTH) provides push, pop, data_o (head, combinational from registered storage), level, empty and full. It has no internal combinational write; storage is written on the clock edge only.
- The top level contains the serialiser FSM, bit and baud counters, overflow and irq logic.

## Test plan
- clk_div=4, 8N1, push 0xA5 → tx: 0 ×4, then 1,0,1,0,0,1,0,1 (4 cycles each), then 1 ×4. tx_done 40 cycles after the start-bit edge; busy drops with it.
- 7E2 and 7O2 with 0x55 → data bits 1,0,1,0,1,0,1, parity 0 (even) / 1 (odd), two stop bits. 44-cycle frame at clk_div=4.
- DEPTH=16: push 17 bytes in consecutive cycles while idle → the first is popped after one cycle. Confirm the 17th is either accepted (one slot freed) or, if full, dropped with overflow=1. Then clr_ovf → overflow=0 next cycle. Simultaneous set and clear → overflow stays 1.
- Queue 3 bytes at 5N1, clk_div=2 (clamped to 4) → three 28-cycle frames with no idle gap. tx_done pulses 3 times. low_wm_irq stays 1 throughout.
- Change cfg_data_bits from 8 to 5 mid-frame → the current frame still sends 8 bits; the next frame sends 5.
- rst_n low during DATA → on the reset edge tx=1, level=0, busy=0. After release, a new push transmits cleanly.
